// File: rtl/milano_pkg.sv
// Shared core package for the milano pipeline.
// Holds the fetch FSM state encoding and the default boot address.
package milano_pkg;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction RAM handshake, EX redirect,
// and the instruction hand-off to ID.
//   master : fetch_ctrl side (drives RAM request and ID outputs)
//   slave  : environment side (RAM, EX, ID)
interface fetch_ctrl_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        branch_valid_i;
    logic [31:0] branch_target_i;
    logic        stall_id_i;
    logic        instr_valid_id_o;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] instr_addr_id_o;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        input  branch_valid_i, branch_target_i, stall_id_i,
        output instr_valid_id_o, instr_rdata_id_o, instr_addr_id_o
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        output branch_valid_i, branch_target_i, stall_id_i,
        input  instr_valid_id_o, instr_rdata_id_o, instr_addr_id_o
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer for a fetched instruction that ID could not accept.
//   clk_i, rst_ni : clock, async active-low reset
//   i_load        : capture i_rdata/i_addr and mark valid
//   i_drain       : entry consumed, mark empty
//   i_clear       : drop the entry (redirect); highest priority
//   o_valid/o_rdata/o_addr : buffered entry
module fetch_hold_buf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_addr,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic [31:0] o_addr
);
    logic        r_valid;
    logic [31:0] r_rdata;
    logic [31:0] r_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_rdata <= i_rdata;
            r_addr  <= i_addr;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_rdata = r_rdata;
    assign o_addr  = r_addr;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding RAM request, a one-entry
// hold buffer for back-pressure from ID, and EX branch redirects that kill
// any in-flight response.
//   clk_i, rst_ni : clock, async active-low reset
//   fetch_if      : fetch_ctrl_if.master (RAM request/response, branch,
//                   ID stall and ID instruction outputs)
module fetch_ctrl
    import milano_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_ctrl_if.master  fetch_if
);
    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic         r_kill, w_kill_next;
    logic [31:0]  r_inflight_addr;
    logic         r_id_valid;
    logic [31:0]  r_id_rdata;
    logic [31:0]  r_id_addr;

    logic         w_branch;
    logic         w_id_free;
    logic         w_latch_inflight;
    logic         w_id_load_mem;
    logic         w_buf_load;
    logic         w_buf_drain;
    logic         w_buf_valid;
    logic [31:0]  w_buf_rdata;
    logic [31:0]  w_buf_addr;

    // Redirects are ignored in BOOT; everywhere else they win over all events.
    assign w_branch  = fetch_if.branch_valid_i && (r_state != BOOT);
    assign w_id_free = !r_id_valid || !fetch_if.stall_id_i;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_kill_next      = r_kill;
        w_latch_inflight = 1'b0;
        w_id_load_mem    = 1'b0;
        w_buf_load       = 1'b0;
        w_buf_drain      = 1'b0;
        case (r_state)
            BOOT: w_state_next = REQ;
            REQ: begin
                if (w_branch) w_pc_next = fetch_if.branch_target_i;
                if (fetch_if.instr_gnt_i) begin
                    w_state_next     = WAIT;
                    w_latch_inflight = 1'b1;
                    // A redirect racing the grant kills the response to come.
                    w_kill_next      = w_branch;
                end
            end
            WAIT: begin
                if (w_branch) begin
                    w_pc_next = fetch_if.branch_target_i;
                    if (fetch_if.instr_rvalid_i) begin
                        w_state_next = REQ;
                        w_kill_next  = 1'b0;
                    end else begin
                        w_kill_next  = 1'b1;
                    end
                end else if (fetch_if.instr_rvalid_i) begin
                    w_state_next = REQ;
                    if (r_kill) begin
                        w_kill_next = 1'b0;
                    end else begin
                        w_pc_next = r_pc + 32'd4;
                        if (w_id_free) begin
                            w_id_load_mem = 1'b1;
                        end else begin
                            w_buf_load   = 1'b1;
                            w_state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_branch) begin
                    w_pc_next    = fetch_if.branch_target_i;
                    w_state_next = REQ;
                end else if (!fetch_if.stall_id_i) begin
                    w_buf_drain  = 1'b1;
                    w_state_next = REQ;
                end
            end
            default: w_state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= BOOT;
            r_pc            <= BOOT_ADDR;
            r_kill          <= 1'b0;
            r_inflight_addr <= BOOT_ADDR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_kill  <= w_kill_next;
            if (w_latch_inflight) r_inflight_addr <= r_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_valid <= 1'b0;
            r_id_rdata <= '0;
            r_id_addr  <= '0;
        end else if (w_branch) begin
            r_id_valid <= 1'b0;
        end else if (w_id_load_mem) begin
            r_id_valid <= 1'b1;
            r_id_rdata <= fetch_if.instr_rdata_i;
            r_id_addr  <= r_inflight_addr;
        end else if (w_buf_drain && w_buf_valid) begin
            r_id_valid <= 1'b1;
            r_id_rdata <= w_buf_rdata;
            r_id_addr  <= w_buf_addr;
        end else if (r_id_valid && !fetch_if.stall_id_i) begin
            r_id_valid <= 1'b0;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_load  (w_buf_load),
        .i_drain (w_buf_drain),
        .i_clear (w_branch),
        .i_rdata (fetch_if.instr_rdata_i),
        .i_addr  (r_inflight_addr),
        .o_valid (w_buf_valid),
        .o_rdata (w_buf_rdata),
        .o_addr  (w_buf_addr)
    );

    assign fetch_if.instr_req_o      = (r_state == REQ);
    assign fetch_if.instr_addr_o     = r_pc;
    assign fetch_if.instr_valid_id_o = r_id_valid;
    assign fetch_if.instr_rdata_id_o = r_id_rdata;
    assign fetch_if.instr_addr_id_o  = r_id_addr;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_fetch_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fetch_ctrl_if bus();

    fetch_ctrl #(.BOOT_ADDR(32'h0000_0000)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .fetch_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    // Apply one cycle of inputs, then advance to 1 unit after the next edge.
    task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic br, input logic [31:0] tgt, input logic st);
        bus.instr_gnt_i     = g;
        bus.instr_rvalid_i  = rv;
        bus.instr_rdata_i   = rd;
        bus.branch_valid_i  = br;
        bus.branch_target_i = tgt;
        bus.stall_id_i      = st;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.instr_gnt_i     = 1'b0;
        bus.instr_rvalid_i  = 1'b0;
        bus.instr_rdata_i   = '0;
        bus.branch_valid_i  = 1'b0;
        bus.branch_target_i = '0;
        bus.stall_id_i      = 1'b0;
    endtask

    // Leaves the bench in cycle 0 after release (FSM in BOOT).
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reach cycle 5: ID holds addr 4, FSM in REQ for addr 8.
    task automatic run_to_c5();
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h0), 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h4), 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        n_checks++;
        if (bus.instr_req_o !== 1'b0 || bus.instr_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_req: req=%b addr=%h, required req=0 addr=00000000", bus.instr_req_o, bus.instr_addr_o);
        end
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b0 || bus.instr_rdata_id_o !== 32'h0 || bus.instr_addr_id_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_id: valid=%b rdata=%h addr=%h, required 0/00000000/00000000",
                     bus.instr_valid_id_o, bus.instr_rdata_id_o, bus.instr_addr_id_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (bus.instr_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL boot_noreq: req=%b, required 0", bus.instr_req_o);
        end
        // Branch in BOOT must be ignored.
        step(0, 0, 0, 1, 32'h40, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL boot_branch_ignored: req=%b addr=%h, required req=1 addr=00000000", bus.instr_req_o, bus.instr_addr_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL basic_first_req: req=%b addr=%h, required req=1 addr=00000000", bus.instr_req_o, bus.instr_addr_o);
        end
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_wait_noreq: req=%b, required 0", bus.instr_req_o);
        end
        step(0, 1, dat(32'h0), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h0 || bus.instr_rdata_id_o !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("FAIL basic_id0: valid=%b addr=%h rdata=%h, required 1/00000000/A5A5A5A5",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h4) begin
            n_errors++;
            $display("FAIL basic_req4: req=%b addr=%h, required req=1 addr=00000004", bus.instr_req_o, bus.instr_addr_o);
        end
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_valid_drop: valid=%b, required 0", bus.instr_valid_id_o);
        end
        step(0, 1, dat(32'h4), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h4 || bus.instr_rdata_id_o !== 32'hA5A5A5A1) begin
            n_errors++;
            $display("FAIL basic_id4: valid=%b addr=%h rdata=%h, required 1/00000004/A5A5A5A1",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h8), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h8 || bus.instr_rdata_id_o !== 32'hA5A5A5AD) begin
            n_errors++;
            $display("FAIL basic_id8: valid=%b addr=%h rdata=%h, required 1/00000008/A5A5A5AD",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
    endtask

    task automatic test_stall();
        run_to_c5();
        step(1, 0, 0, 0, 0, 1);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h4 || bus.instr_rdata_id_o !== 32'hA5A5A5A1) begin
            n_errors++;
            $display("FAIL stall_frozen_c6: valid=%b addr=%h rdata=%h, required 1/00000004/A5A5A5A1",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
        step(0, 1, dat(32'h8), 0, 0, 1);
        for (int unsigned i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.instr_req_o !== 1'b0 || bus.instr_valid_id_o !== 1'b1 ||
                bus.instr_addr_id_o !== 32'h4 || bus.instr_rdata_id_o !== 32'hA5A5A5A1) begin
                n_errors++;
                $display("FAIL stall_hold_%0d: req=%b valid=%b addr=%h rdata=%h, required req=0 1/00000004/A5A5A5A1",
                         i, bus.instr_req_o, bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
            end
            if (i < 3) step(0, 0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h8 || bus.instr_rdata_id_o !== 32'hA5A5A5AD) begin
            n_errors++;
            $display("FAIL stall_release_id8: valid=%b addr=%h rdata=%h, required 1/00000008/A5A5A5AD",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'hC) begin
            n_errors++;
            $display("FAIL stall_release_req12: req=%b addr=%h, required req=1 addr=0000000c", bus.instr_req_o, bus.instr_addr_o);
        end
    endtask

    task automatic test_branch_wait();
        run_to_c5();
        step(1, 0, 0, 0, 0, 0);
        // Branch with stall asserted and a live ID instruction.
        step(0, 0, 0, 1, 32'h100, 1);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b0 || bus.instr_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bwait_flush: valid=%b req=%b, required valid=0 req=0", bus.instr_valid_id_o, bus.instr_req_o);
        end
        step(0, 1, dat(32'h8), 0, 0, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h100 || bus.instr_valid_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bwait_req100: req=%b addr=%h valid=%b, required req=1 addr=00000100 valid=0",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_id_o);
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h100), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h100 || bus.instr_rdata_id_o !== 32'hA5A5A4A5 ||
            bus.instr_addr_o !== 32'h104) begin
            n_errors++;
            $display("FAIL bwait_id100: valid=%b addr=%h rdata=%h pc=%h, required 1/00000100/A5A5A4A5 pc=00000104",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o, bus.instr_addr_o);
        end
    endtask

    task automatic test_branch_gnt();
        run_to_c5();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h8), 0, 0, 0);
        step(1, 0, 0, 1, 32'h200, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b0 || bus.instr_valid_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bgnt_wait: req=%b valid=%b, required req=0 valid=0", bus.instr_req_o, bus.instr_valid_id_o);
        end
        step(0, 1, dat(32'hC), 0, 0, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h200 || bus.instr_valid_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bgnt_req200: req=%b addr=%h valid=%b, required req=1 addr=00000200 valid=0",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_id_o);
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h200), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h200 || bus.instr_rdata_id_o !== 32'hA5A5A7A5) begin
            n_errors++;
            $display("FAIL bgnt_id200: valid=%b addr=%h rdata=%h, required 1/00000200/A5A5A7A5",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
    endtask

    task automatic test_branch_req();
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h300, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h300) begin
            n_errors++;
            $display("FAIL breq_req300: req=%b addr=%h, required req=1 addr=00000300", bus.instr_req_o, bus.instr_addr_o);
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h300), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h300 || bus.instr_rdata_id_o !== 32'hA5A5A6A5) begin
            n_errors++;
            $display("FAIL breq_id300: valid=%b addr=%h rdata=%h, required 1/00000300/A5A5A6A5",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
        step(1, 0, 0, 0, 0, 0);
        // Branch coincides with the response: data discarded.
        step(0, 1, dat(32'h304), 1, 32'h400, 0);
        n_checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h400 || bus.instr_valid_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bwrv_req400: req=%b addr=%h valid=%b, required req=1 addr=00000400 valid=0",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_id_o);
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h400), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h400 || bus.instr_rdata_id_o !== 32'hA5A5A1A5) begin
            n_errors++;
            $display("FAIL bwrv_id400: valid=%b addr=%h rdata=%h, required 1/00000400/A5A5A1A5",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
    endtask

    task automatic test_branch_hold();
        run_to_c5();
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, dat(32'h8), 0, 0, 1);
        step(0, 0, 0, 1, 32'h500, 1);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b0 || bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h500) begin
            n_errors++;
            $display("FAIL bhold_flush: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000500",
                     bus.instr_valid_id_o, bus.instr_req_o, bus.instr_addr_o);
        end
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bhold_buf_dropped: valid=%b addr=%h, required valid=0", bus.instr_valid_id_o, bus.instr_addr_id_o);
        end
        step(0, 1, dat(32'h500), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h500 || bus.instr_rdata_id_o !== 32'hA5A5A0A5) begin
            n_errors++;
            $display("FAIL bhold_id500: valid=%b addr=%h rdata=%h, required 1/00000500/A5A5A0A5",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'hFFFF_FFFC), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'hFFFF_FFFC || bus.instr_rdata_id_o !== 32'h5A5A_5A59 ||
            bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap: valid=%b addr=%h rdata=%h req=%b pc=%h, required 1/fffffffc/5a5a5a59 req=1 pc=00000000",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o, bus.instr_req_o, bus.instr_addr_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_checks++;
        if (bus.instr_req_o !== 1'b0 || bus.instr_addr_o !== 32'h0 || bus.instr_valid_id_o !== 1'b0 || bus.instr_rdata_id_o !== 32'h0) begin
            n_errors++;
            $display("FAIL midrst_async: req=%b addr=%h valid=%b rdata=%h, required 0/00000000/0/00000000",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_id_o, bus.instr_rdata_id_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b0 || bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL midrst_stray: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000000",
                     bus.instr_valid_id_o, bus.instr_req_o, bus.instr_addr_o);
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, dat(32'h0), 0, 0, 0);
        n_checks++;
        if (bus.instr_valid_id_o !== 1'b1 || bus.instr_addr_id_o !== 32'h0 || bus.instr_rdata_id_o !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("FAIL midrst_restart: valid=%b addr=%h rdata=%h, required 1/00000000/A5A5A5A5",
                     bus.instr_valid_id_o, bus.instr_addr_id_o, bus.instr_rdata_id_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_branch_gnt();
        test_branch_req();
        test_branch_hold();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
